// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and sizing constants.
package alu_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_WIDTH = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub_rca.sv
// Ripple-borrow subtractor a - b built as a ripple-carry adder of a + ~b + 1.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module sub_rca #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_adder u_fa (
      .a    (a[gi]),
      .b    (~b[gi]),
      .cin  (carry[gi]),
      .sum  (diff[gi]),
      .cout (carry[gi+1])
    );
  end

  // A missing carry-out of the two's-complement add means a < b.
  assign borrow = ~carry[WIDTH];
endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider, one shift-subtract step per clock.
module seq_divider_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   m_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             take_diff;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  assign trial = {a_reg, q_reg[WIDTH-1]};

  sub_rca #(.WIDTH(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      (m_reg),
    .diff   (diff),
    .borrow (borrow)
  );

  // Without a borrow the difference is below M, so its top bit is always
  // clear; A therefore only needs WIDTH bits between iterations.
  assign take_diff = ~borrow & ~diff[WIDTH];
  assign a_next    = take_diff ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next    = {q_reg[WIDTH-2:0], take_diff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      count_reg   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              a_reg       <= '0;
              q_reg       <= dividend;
              m_reg       <= {1'b0, divisor};
              count_reg   <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          a_reg     <= a_next;
          q_reg     <= q_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CNT_LAST) begin
            quotient  <= q_next;
            remainder <= a_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_16bit.sv
// Randomised self-checking bench for seq_divider_16bit against integer / and %.
module tb_seq_divider_16bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_q = '0;
  logic [15:0] prev_r = '0;

  always #5 clk = ~clk;

  seq_divider_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One request; inject_at >= 0 pulses a second (ignored) start at that cycle.
  task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs,
                        input int inject_at, input bit invariant);
    logic [15:0] exp_q, exp_r;
    logic [31:0] recon;
    int first_done, busy_n, done_n, exp_lat;
    bit moved;
    if (dvs == 0) begin
      exp_q = 16'hFFFF; exp_r = dvd; exp_lat = 0;
    end else begin
      exp_q = dvd / dvs; exp_r = dvd % dvs; exp_lat = 16;
    end
    @(negedge clk);
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    first_done = -1; busy_n = 0; done_n = 0; moved = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      if (n == inject_at) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (first_done < 0) first_done = n;
      end
      if (first_done < 0 && (quotient !== prev_q || remainder !== prev_r)) moved = 1'b1;
    end
    start = 1'b0;
    check("latency", first_done, exp_lat);
    check("done_pulses", done_n, 1);
    check("busy_cycles", busy_n, (dvs == 0) ? 0 : 16);
    check("hold_before_done", {31'd0, moved}, 0);
    check("quotient", {16'd0, quotient}, {16'd0, exp_q});
    check("remainder", {16'd0, remainder}, {16'd0, exp_r});
    check("div_by_zero", {31'd0, div_by_zero}, (dvs == 0) ? 1 : 0);
    if (invariant) begin
      recon = 32'(quotient) * 32'(dvs) + 32'(remainder);
      check("q*d+r", recon, {16'd0, dvd});
      check("r<d", {31'd0, remainder < dvs}, 1);
    end
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b (expect q=%0d r=%0d)",
             dvd, dvs, quotient, remainder, div_by_zero, exp_q, exp_r);
    prev_q = exp_q;
    prev_r = exp_r;
  endtask

  initial begin
    int done_seen;
    logic [15:0] rd, rv;
    repeat (2) @(negedge clk);
    check("rst_quotient", {16'd0, quotient}, 0);
    check("rst_remainder", {16'd0, remainder}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_dbz", {31'd0, div_by_zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'd100, 16'd7, -1, 1'b1);
    run_op(16'hFFFF, 16'h0001, -1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, -1, 1'b1);
    run_op(16'd5, 16'd9, -1, 1'b1);
    run_op(16'd1234, 16'd0, -1, 1'b0);
    run_op(16'd10, 16'd3, -1, 1'b1);
    run_op(16'd200, 16'd9, 5, 1'b1);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    check("async_quotient", {16'd0, quotient}, 0);
    check("async_remainder", {16'd0, remainder}, 0);
    check("async_busy", {31'd0, busy}, 0);
    check("async_done", {31'd0, done}, 0);
    check("async_dbz", {31'd0, div_by_zero}, 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
    prev_q = '0;
    prev_r = '0;
    run_op(16'd1000, 16'd3, -1, 1'b1);

    for (int i = 0; i < 500; i++) begin
      rd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rv = 16'($urandom_range(1, 15));
        1: rv = 16'($urandom_range(1, 255));
        default: rv = 16'($urandom_range(1, 65535));
      endcase
      run_op(rd, rv, -1, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider_16bit.md
Name: seq_divider_16bit

Overview:
Multi-cycle unsigned restoring divider. It computes the quotient and remainder of dividend/divisor using one shift-subtract iteration per clock. It is the inverse-direction companion to the team's ripple-carry adder datapath and reuses a ripple-borrow subtractor as its only arithmetic element. It sits beside the adders in the ALU and is driven by a start/done handshake.

Parameters:
WIDTH, 16, operand/quotient/remainder width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, captured on accepted start
divisor  input  WIDTH  unsigned divisor, captured on accepted start
quotient  output  WIDTH  result quotient, registered
remainder  output  WIDTH  result remainder, registered
busy  output  1  high while in CALC
done  output  1  one-cycle pulse, high in DONE
div_by_zero  output  1  set with done when captured divisor==0; held until next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; iteration counter=0; internal A/Q/M cleared.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge E0, divisor!=0: load A(WIDTH+1 bits)=0, Q=dividend, M={0,divisor}, count=0, clear div_by_zero; go to CALC.
- IDLE, start=1, divisor==0: go directly to DONE at E0. quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- CALC, each edge:
  - T={A[WIDTH-1:0],Q[WIDTH-1]}; Q shifts left.
  - D=T-M via the subtractor.
  - If there is no borrow: A=D and Q[0]=1. Otherwise A=T and Q[0]=0.
  - count+1.
- CALC exit: on the WIDTH-th CALC edge (count==WIDTH-1), register quotient=final Q and remainder=final A[WIDTH-1:0], then go to DONE.
- Latency: with divisor!=0, done is high during the cycle after edge E0+WIDTH (E16 for the default).
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Start handling: start is ignored in CALC and DONE (no queuing). A new request requires start in IDLE.
- Result persistence: quotient/remainder/div_by_zero hold their values after DONE until the next accepted start's result overwrites them. They do not change during CALC; intermediate state stays internal.
- Operand stability: dividend/divisor are don't-care after the acceptance edge.
- Width rules:
  - Partial remainder is WIDTH+1 bits, so T never overflows.
  - Borrow is the subtractor's borrow-out of the WIDTH+1-bit subtraction.
  - All arithmetic is unsigned.
- Reset mid-CALC: abort immediately to the reset values. No done pulse is produced. The next start in IDLE behaves normally.
- Invariant (divisor!=0): dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package (alu_pkg): state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2; DIV_WIDTH=16; counter width $clog2(DIV_WIDTH).
- Sub-module sub_rca:
  - Parameterised WIDTH+1-bit ripple-borrow subtractor (a - b, borrow out).
  - Built from full_adder instances with inverted b and carry-in 1; borrow = ~carry-out.
  - Instantiated once.
- FSM, counter and shift registers live in seq_divider_16bit.

Test Plan:
- dividend=100, divisor=7, start pulse in IDLE -> busy for 16 cycles; done pulses once, 16 edges after acceptance; quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0. Then 0xFFFF/0xFFFF -> quotient=1, remainder=0. Then 5/9 -> quotient=0, remainder=5.
- 1234/0 -> done on the cycle after the acceptance edge, with no CALC cycles; quotient=0xFFFF, remainder=1234, div_by_zero=1. Next op 10/3 -> div_by_zero=0, quotient=3, remainder=1.
- Busy handling: start 200/9, then pulse start with 50/5 during CALC cycle 5 -> second request ignored; result quotient=22, remainder=2; exactly one done pulse.
- Reset mid-op: start 1000/3, assert rst asynchronously mid-cycle at CALC cycle 8 -> outputs drop to 0 without waiting for a clock; no done. Release rst, start 1000/3 -> quotient=333, remainder=1.
- Randomised sweep: 500 operand pairs with divisor!=0 -> quotient*divisor+remainder==dividend and remainder<divisor; outputs stable between done and the next start.
